// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipeline stage register.
//   NOP_WD          destination address used by a NOP lane (register zero)
//   STALL_STOP/GO   encodings of one stall-vector bit
//   DEFAULT_DATA_W  default per-lane write-data width
//   DEFAULT_CNT_W   default statistics counter width
//   stage_act_t     what the stage does on a clock edge
//   decode_act()    maps flush and the two relevant stall bits to an action
package pipe_pkg;

    localparam logic [4:0] NOP_WD         = 5'd0;
    localparam logic       STALL_STOP     = 1'b1;
    localparam logic       STALL_GO       = 1'b0;
    localparam int         DEFAULT_DATA_W = 32;
    localparam int         DEFAULT_CNT_W  = 16;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_t;

    // Priority: flush, then bubble, then hold, then advance.
    // A bubble means this stage stops while the next one keeps going, so the
    // next stage must receive a NOP; a hold means both stop, so the contents
    // are kept.
    function automatic stage_act_t decode_act(input logic flush,
                                              input logic stall_self,
                                              input logic stall_next);
        stage_act_t act;
        if (flush)
            act = ACT_FLUSH;
        else if (stall_self == STALL_STOP && stall_next == STALL_GO)
            act = ACT_BUBBLE;
        else if (stall_self == STALL_STOP)
            act = ACT_HOLD;
        else
            act = ACT_ADVANCE;
        return act;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at its maximum value.
//   clk    clock, rising edge
//   rst    asynchronous active-low reset, clears the count
//   inc    add one on this edge (ignored once saturated)
//   clr    synchronous clear, overrides inc
//   count  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-lane write-back pipeline register with flush, bubble
// and hold control, same-address write suppression and stall statistics.
//   clk, rst              clock; asynchronous active-low reset
//   stall[STALL_W]        pipeline stall vector, bit STALL_IDX is this stage,
//                         bit STALL_IDX+1 the stage after it
//   flush                 discard the stage contents
//   cnt_clr               synchronous clear of both statistics counters
//   in_valid/in_wreg      per-lane valid and register-write enable
//   in_wd                 per-lane 5-bit destination, lane k at [5k+4:5k]
//   in_wdata              per-lane write data, lane k at the k-th DATA_W slice
//   out_*                 registered copies of the lanes after masking
//   conflict              one-cycle flag: a same-address write was suppressed
//   bubble_cnt/hold_cnt   saturating counts of bubble and hold edges
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int LANES     = 2,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = 4,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic                    cnt_clr,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0]        in_wreg,
    input  logic [LANES*5-1:0]      in_wd,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES-1:0]        out_wreg,
    output logic [LANES*5-1:0]      out_wd,
    output logic [LANES*DATA_W-1:0] out_wdata,
    output logic                    conflict,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        hold_cnt
);

    stage_act_t act;
    assign act = decode_act(flush, stall[STALL_IDX], stall[STALL_IDX+1]);

    // Only two stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    // ------------------------------------------------------------------
    // Lane masking, ahead of the registers
    // ------------------------------------------------------------------
    // wreg_eff: the lane would really write a register (valid, enabled and
    // not register zero).
    logic [LANES-1:0]        wreg_eff;
    logic [LANES-1:0]        supp;
    logic [LANES*LANES-1:0]  pair_hit;
    logic [LANES*5-1:0]      nxt_wd;
    logic [LANES*DATA_W-1:0] nxt_wdata;
    logic [LANES-1:0]        nxt_wreg;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign wreg_eff[k] = in_valid[k] & in_wreg[k] & (in_wd[5*k +: 5] != NOP_WD);
        assign nxt_wd[5*k +: 5] = in_valid[k] ? in_wd[5*k +: 5] : NOP_WD;
        assign nxt_wdata[DATA_W*k +: DATA_W] =
            in_valid[k] ? in_wdata[DATA_W*k +: DATA_W] : '0;
    end

    // pair_hit[i*LANES+j] is set when the younger lane j (j > i) writes the
    // same register as lane i; lane i's write is then dropped.
    for (genvar i = 0; i < LANES; i++) begin : g_row
        for (genvar j = 0; j < LANES; j++) begin : g_col
            if (j > i) begin : g_pair
                assign pair_hit[i*LANES+j] = wreg_eff[i] & wreg_eff[j] &
                                             (in_wd[5*i +: 5] == in_wd[5*j +: 5]);
            end else begin : g_nopair
                assign pair_hit[i*LANES+j] = 1'b0;
            end
        end
        assign supp[i] = |pair_hit[i*LANES +: LANES];
    end

    assign nxt_wreg = wreg_eff & ~supp;

    // ------------------------------------------------------------------
    // Lane registers and conflict flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= '0;
            out_wreg  <= '0;
            out_wd    <= '0;
            out_wdata <= '0;
            conflict  <= 1'b0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    out_valid <= '0;
                    out_wreg  <= '0;
                    out_wd    <= '0;
                    out_wdata <= '0;
                    conflict  <= 1'b0;
                end
                ACT_ADVANCE: begin
                    out_valid <= in_valid;
                    out_wreg  <= nxt_wreg;
                    out_wd    <= nxt_wd;
                    out_wdata <= nxt_wdata;
                    conflict  <= |supp;
                end
                default: begin
                    // hold: everything keeps its value
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_BUBBLE),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_HOLD),
        .clr   (cnt_clr),
        .count (hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios plus randomized traffic for
// pipe_stage_reg, checked every cycle against a behavioural model.
module tb_pipe_stage_reg;

    localparam int LANES     = 2;
    localparam int DATA_W    = 32;
    localparam int STALL_W   = 6;
    localparam int STALL_IDX = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic                    cnt_clr;
    logic [LANES-1:0]        in_valid;
    logic [LANES-1:0]        in_wreg;
    logic [LANES*5-1:0]      in_wd;
    logic [LANES*DATA_W-1:0] in_wdata;
    logic [LANES-1:0]        out_valid;
    logic [LANES-1:0]        out_wreg;
    logic [LANES*5-1:0]      out_wd;
    logic [LANES*DATA_W-1:0] out_wdata;
    logic                    conflict;
    logic [CNT_W-1:0]        bubble_cnt;
    logic [CNT_W-1:0]        hold_cnt;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .LANES(LANES), .STALL_W(STALL_W),
        .STALL_IDX(STALL_IDX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_wreg(in_wreg), .in_wd(in_wd), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_wreg(out_wreg), .out_wd(out_wd),
        .out_wdata(out_wdata), .conflict(conflict),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid [LANES];
    logic        m_wreg  [LANES];
    logic [4:0]  m_wd    [LANES];
    logic [31:0] m_wdata [LANES];
    logic        m_conflict;
    int          m_bubble;
    int          m_hold;

    task automatic model_clear();
        for (int k = 0; k < LANES; k++) begin
            m_valid[k] = 1'b0;
            m_wreg[k]  = 1'b0;
            m_wd[k]    = 5'd0;
            m_wdata[k] = 32'd0;
        end
        m_conflict = 1'b0;
        m_bubble   = 0;
        m_hold     = 0;
    endtask

    task automatic model_step();
        logic me, nx, is_bubble, is_hold, hit;
        logic [4:0] wdi;
        me = stall[STALL_IDX];
        nx = stall[STALL_IDX+1];
        is_bubble = !flush && me && !nx;
        is_hold   = !flush && me && nx;
        // statistics
        if (cnt_clr) begin
            m_bubble = 0;
            m_hold   = 0;
        end else if (is_bubble) begin
            if (m_bubble < CNT_MAX) m_bubble++;
        end else if (is_hold) begin
            if (m_hold < CNT_MAX) m_hold++;
        end
        // lanes
        if (flush || is_bubble) begin
            for (int k = 0; k < LANES; k++) begin
                m_valid[k] = 1'b0;
                m_wreg[k]  = 1'b0;
                m_wd[k]    = 5'd0;
                m_wdata[k] = 32'd0;
            end
            m_conflict = 1'b0;
        end else if (!is_hold) begin
            m_conflict = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                wdi = in_wd[5*i +: 5];
                if (!in_valid[i]) begin
                    m_valid[i] = 1'b0;
                    m_wreg[i]  = 1'b0;
                    m_wd[i]    = 5'd0;
                    m_wdata[i] = 32'd0;
                end else begin
                    m_valid[i] = 1'b1;
                    m_wd[i]    = wdi;
                    m_wdata[i] = in_wdata[DATA_W*i +: DATA_W];
                    m_wreg[i]  = in_wreg[i] && (wdi != 5'd0);
                    // a younger lane writing the same register wins
                    hit = 1'b0;
                    for (int j = i + 1; j < LANES; j++)
                        if (in_valid[j] && in_wreg[j] && in_wd[5*j +: 5] == wdi)
                            hit = 1'b1;
                    if (m_wreg[i] && hit) begin
                        m_wreg[i]  = 1'b0;
                        m_conflict = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else      model_step();
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [LANES-1:0]        e_valid, e_wreg;
        logic [LANES*5-1:0]      e_wd;
        logic [LANES*DATA_W-1:0] e_wdata;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < LANES; k++) begin
                e_valid[k] = m_valid[k];
                e_wreg[k]  = m_wreg[k];
                e_wd[5*k +: 5] = m_wd[k];
                e_wdata[DATA_W*k +: DATA_W] = m_wdata[k];
            end
            chk("cyc_valid", 64'(out_valid), 64'(e_valid));
            chk("cyc_wreg", 64'(out_wreg), 64'(e_wreg));
            chk("cyc_wd", 64'(out_wd), 64'(e_wd));
            chk("cyc_wdata", 64'(out_wdata), 64'(e_wdata));
            chk("cyc_conflict", 64'(conflict), 64'(m_conflict));
            chk("cyc_bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
            chk("cyc_hold_cnt", 64'(hold_cnt), 64'(m_hold));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic [STALL_W-1:0] s, input logic f, input logic c);
        stall   = s;
        flush   = f;
        cnt_clr = c;
    endtask

    task automatic set_lanes(input logic [1:0] v, input logic [1:0] w,
                             input logic [4:0] wd0, input logic [4:0] wd1,
                             input logic [31:0] d0, input logic [31:0] d1);
        in_valid = v;
        in_wreg  = w;
        in_wd    = {wd1, wd0};
        in_wdata = {d1, d0};
    endtask

    task automatic rand_lanes();
        set_lanes(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [5:0] ST_GO     = 6'b000000;
    localparam logic [5:0] ST_BUBBLE = 6'b010000;
    localparam logic [5:0] ST_HOLD   = 6'b110000;

    initial begin
        int r;
        set_ctl(ST_GO, 1'b0, 1'b0);
        set_lanes(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);

        // reset held with random traffic: everything stays zero
        for (int c = 0; c < 5; c++) begin
            rand_lanes();
            set_ctl(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0);
            step();
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_wdata", 64'(out_wdata), 64'd0);
            chk("rst_cnts", 64'({bubble_cnt, hold_cnt, conflict}), 64'd0);
        end

        // first edge after release advances normally
        rst = 1'b1;
        set_ctl(ST_GO, 1'b0, 1'b0);
        set_lanes(2'b11, 2'b00, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5);
        step();
        chk("rel_valid", 64'(out_valid), 64'h3);
        chk("rel_wd", 64'(out_wd), 64'h063);
        chk("rel_wdata", 64'(out_wdata), 64'hA5A5A5A5A5A5A5A5);
        chk("rel_wreg", 64'(out_wreg), 64'h0);

        // bubble then three holds
        set_ctl(ST_BUBBLE, 1'b0, 1'b0);
        step();
        chk("bub_valid", 64'(out_valid), 64'h0);
        chk("bub_wdata", 64'(out_wdata), 64'h0);
        chk("bub_cnt", 64'(bubble_cnt), 64'd1);
        set_ctl(ST_HOLD, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            rand_lanes();
            step();
        end
        chk("hold_valid", 64'(out_valid), 64'h0);
        chk("hold_cnt3", 64'(hold_cnt), 64'd3);
        chk("hold_bub1", 64'(bubble_cnt), 64'd1);

        // same-address conflict: younger lane 1 wins
        set_ctl(ST_GO, 1'b0, 1'b0);
        set_lanes(2'b11, 2'b11, 5'd5, 5'd5, 32'h11, 32'h22);
        step();
        chk("cf_wreg", 64'(out_wreg), 64'h2);
        chk("cf_wdata", 64'(out_wdata), 64'h0000002200000011);
        chk("cf_flag", 64'(conflict), 64'd1);
        set_lanes(2'b11, 2'b11, 5'd5, 5'd6, 32'h33, 32'h44);
        step();
        chk("cf_clear", 64'(conflict), 64'd0);
        chk("cf_wreg2", 64'(out_wreg), 64'h3);

        // register zero never writes
        set_lanes(2'b11, 2'b11, 5'd0, 5'd7, 32'h55, 32'h66);
        step();
        chk("r0_wreg", 64'(out_wreg), 64'h2);
        chk("r0_valid", 64'(out_valid), 64'h3);
        chk("r0_wd", 64'(out_wd), 64'h0E0);

        // hold freezes live contents, then flush beats hold
        set_ctl(ST_HOLD, 1'b0, 1'b0);
        rand_lanes();
        step();
        step();
        chk("frz_wdata", 64'(out_wdata), 64'h0000006600000055);
        chk("frz_hold5", 64'(hold_cnt), 64'd5);
        set_ctl(ST_HOLD, 1'b1, 1'b0);
        step();
        chk("fl_valid", 64'(out_valid), 64'h0);
        chk("fl_wdata", 64'(out_wdata), 64'h0);
        chk("fl_hold5", 64'(hold_cnt), 64'd5);

        // reset in the middle of a hold clears at once, between clock edges
        set_ctl(ST_GO, 1'b0, 1'b0);
        set_lanes(2'b11, 2'b01, 5'd9, 5'd10, 32'hDEAD0001, 32'hBEEF0002);
        step();
        set_ctl(ST_HOLD, 1'b0, 1'b0);
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_wdata", 64'(out_wdata), 64'h0);
        chk("arst_hold", 64'(hold_cnt), 64'd0);
        step();
        rst = 1'b1;
        set_ctl(ST_GO, 1'b0, 1'b0);
        set_lanes(2'b11, 2'b10, 5'd12, 5'd13, 32'h01234567, 32'h89ABCDEF);
        step();
        chk("post_wdata", 64'(out_wdata), 64'h89ABCDEF01234567);
        chk("post_wreg", 64'(out_wreg), 64'h2);

        // saturation and clear-over-increment
        set_ctl(ST_HOLD, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) step();
        chk("sat_hold", 64'(hold_cnt), 64'd15);
        set_ctl(ST_HOLD, 1'b0, 1'b1);
        step();
        chk("clr_hold", 64'(hold_cnt), 64'd0);
        chk("clr_lanes", 64'(out_wdata), 64'h89ABCDEF01234567);

        // randomized traffic, with occasional asynchronous resets
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 9);
            stall = 6'($urandom_range(0, 63));
            if (r < 6) begin
                stall[STALL_IDX] = 1'b0;
            end else if (r < 8) begin
                stall[STALL_IDX]   = 1'b1;
                stall[STALL_IDX+1] = 1'b0;
            end else begin
                stall[STALL_IDX]   = 1'b1;
                stall[STALL_IDX+1] = 1'b1;
            end
            flush   = ($urandom_range(0, 15) == 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            rand_lanes();
            if ($urandom_range(0, 149) == 0) begin
                #3 rst = 1'b0;
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
